// File: rtl/game_pkg.sv
// Shared constants, event record and drain-FSM encoding for the 6-track lane event scheduler.
package game_pkg;
  localparam int NUM_LANES = 6;
  localparam int LANE_W    = 3;
  localparam int CODE_W    = 4;
  localparam int TIME_W    = 16;

  // Decoder lane codes run LANE_CODE_MIN..NUM_LANES; 0 means no key.
  localparam logic [CODE_W-1:0] LANE_CODE_MIN = 4'd1;

  typedef struct packed {
    logic              press;
    logic [LANE_W-1:0] lane;
  } evt_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } sched_state_t;
endpackage

// File: rtl/track_key_scheduler_if.sv
// Event hand-off bus between the lane scheduler (master) and the judge logic (slave).
interface track_key_scheduler_if;
  import game_pkg::*;

  logic              evt_valid;
  logic              evt_ready;
  logic              evt_press;
  logic [LANE_W-1:0] evt_lane;
  logic [TIME_W-1:0] evt_time;

  modport master (output evt_valid, evt_press, evt_lane, evt_time, input evt_ready);
  modport slave  (input evt_valid, evt_press, evt_lane, evt_time, output evt_ready);
endinterface

// File: rtl/key_evt_fifo.sv
// First-word-fall-through event FIFO; a push while full succeeds only if a pop happens in the same cycle.
module key_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic                   clk_in,
  input  logic                   key_reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap without compare logic.
  always_ff @(posedge clk_in or negedge key_reset) begin
    if (!key_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/track_key_scheduler.sv
// Turns decoder key codes into ordered lane press/release events with per-lane hold tracking.
// Optional feature: define TIMESTAMP_EN to stamp each event with a CLK_PER_TICK-cycle tick count.
module track_key_scheduler #(
  parameter int NUM_LANES    = game_pkg::NUM_LANES,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLK_PER_TICK = 100000
) (
  input  logic                        clk_in,
  input  logic                        key_reset,
  input  logic                        key_state,
  input  logic [game_pkg::CODE_W-1:0] key_ascii,
  track_key_scheduler_if.master       evt,
  output logic [NUM_LANES-1:0]        lane_held,
  output logic                        ovf,
  input  logic                        ovf_clr
);
  import game_pkg::*;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CLK_PER_TICK < 1 ||
      NUM_LANES < 1 || NUM_LANES > 7) begin : g_bad_cfg
    $error("track_key_scheduler: invalid NUM_LANES, FIFO_DEPTH or CLK_PER_TICK");
  end

  logic                        prev_state;
  logic [CODE_W-1:0]           prev_ascii;
  sched_state_t                state;
  logic [NUM_LANES-1:0]        rel_pend;
  logic [NUM_LANES-1:0]        rel_pend_nxt;
  logic                        code_ok, press_det, rel_det, drain_go;
  logic                        push, pop, overflow;
  logic [LANE_W-1:0]           press_lane, drain_lane;
  logic [NUM_LANES-1:0]        held_set, drain_bit;
  evt_t                        push_evt, head_evt;
  logic                        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  function automatic logic [LANE_W-1:0] lowest_idx(input logic [NUM_LANES-1:0] m);
    lowest_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) if (m[i]) lowest_idx = LANE_W'(i);
  endfunction

  always_comb begin
    code_ok    = (key_ascii >= LANE_CODE_MIN) && (key_ascii <= CODE_W'(NUM_LANES));
    press_lane = LANE_W'(key_ascii - LANE_CODE_MIN);
    press_det  = key_state && code_ok && (!prev_state || key_ascii != prev_ascii) &&
                 !lane_held[press_lane];
    rel_det    = prev_state && !key_state;
    // A press owns the FIFO write port this cycle; the drain simply waits.
    drain_go   = (state == DRAIN) && !press_det && (rel_pend != '0);
    drain_lane = lowest_idx(rel_pend);
    drain_bit  = drain_go ? (NUM_LANES'(1) << drain_lane) : '0;
    held_set   = press_det ? (NUM_LANES'(1) << press_lane) : '0;
    rel_pend_nxt   = (rel_pend | (rel_det ? lane_held : '0)) & ~drain_bit;
    push           = press_det || drain_go;
    push_evt.press = press_det;
    push_evt.lane  = press_det ? press_lane : drain_lane;
    pop            = evt.evt_ready && (fifo_count != '0);
    overflow       = push && fifo_full && !pop;
  end

  // Break codes carry no lane, so a release retires every lane held at that moment.
  always_ff @(posedge clk_in or negedge key_reset) begin
    if (!key_reset) begin
      prev_state <= 1'b0;
      prev_ascii <= '0;
      state      <= IDLE;
      rel_pend   <= '0;
      lane_held  <= '0;
      ovf        <= 1'b0;
    end else begin
      prev_state <= key_state;
      prev_ascii <= key_ascii;
      lane_held  <= (lane_held | held_set) & ~drain_bit;
      if (overflow)     ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      case (state)
        IDLE: begin
          if (rel_det && lane_held != '0) begin
            rel_pend <= lane_held;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          rel_pend <= rel_pend_nxt;
          if (rel_pend_nxt == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TIMESTAMP_EN
  localparam int PRE_W  = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int FIFO_W = TIME_W + $bits(evt_t);

  logic [PRE_W-1:0]  prescale;
  logic [TIME_W-1:0] tick, head_time;
  logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;

  always_ff @(posedge clk_in or negedge key_reset) begin
    if (!key_reset) begin
      prescale <= '0;
      tick     <= '0;
    end else if (prescale == PRE_W'(CLK_PER_TICK - 1)) begin
      prescale <= '0;
      tick     <= tick + TIME_W'(1);
    end else begin
      prescale <= prescale + PRE_W'(1);
    end
  end

  assign fifo_wdata            = {tick, push_evt};
  assign {head_time, head_evt} = fifo_rdata;
`else
  localparam int FIFO_W = $bits(evt_t);

  logic [TIME_W-1:0] head_time;
  logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;

  assign fifo_wdata = push_evt;
  assign head_evt   = fifo_rdata;
  assign head_time  = '0;
`endif

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk_in    (clk_in),
    .key_reset (key_reset),
    .push      (push),
    .push_data (fifo_wdata),
    .pop       (pop),
    .head      (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Head fields are masked while empty so the bus reads all-zero after reset.
  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_press = !fifo_empty && head_evt.press;
  assign evt.evt_lane  = fifo_empty ? '0 : head_evt.lane;
  assign evt.evt_time  = fifo_empty ? '0 : head_time;
endmodule

// File: tb/tb_track_key_scheduler.sv
// Directed bench for track_key_scheduler: vector table plus hand-written overflow/reset sequences.
module tb_track_key_scheduler;
  logic       clk_in = 1'b0;
  logic       key_reset;
  logic       key_state;
  logic [3:0] key_ascii;
  logic [5:0] lane_held;
  logic       ovf;
  logic       ovf_clr;
  int         n_chk  = 0;
  int         n_fail = 0;

  typedef struct {
    logic       st;
    logic [3:0] asc;
    logic       rdy;
    logic       v;
    logic       p;
    logic [2:0] l;
    logic [5:0] held;
  } vec_t;

  vec_t       tbl [23];
  logic       exp_p [8];
  logic [2:0] exp_l [8];
  logic       stray;
  logic [15:0] exp_time;

  track_key_scheduler_if evt_if ();

  track_key_scheduler #(
    .NUM_LANES    (6),
    .FIFO_DEPTH   (8),
    .CLK_PER_TICK (4)
  ) dut (
    .clk_in    (clk_in),
    .key_reset (key_reset),
    .key_state (key_state),
    .key_ascii (key_ascii),
    .evt       (evt_if),
    .lane_held (lane_held),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(input logic p, input logic [2:0] l, input string nm);
    chk({nm, ".valid"}, 32'(evt_if.evt_valid), 32'd1);
    chk({nm, ".press"}, 32'(evt_if.evt_press), 32'(p));
    chk({nm, ".lane"},  32'(evt_if.evt_lane),  32'(l));
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
  endtask

  initial begin
    // {state, ascii, ready} -> {valid, press, lane, lane_held} after the edge
    tbl[0]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 6'h00};
    tbl[1]  = '{1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 3'd2, 6'h04};
    tbl[2]  = '{1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 3'd2, 6'h04};
    tbl[3]  = '{1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 3'd2, 6'h04};
    tbl[4]  = '{1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 3'd2, 6'h04};
    tbl[5]  = '{1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 3'd2, 6'h04};
    tbl[6]  = '{1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 3'd2, 6'h04};
    tbl[7]  = '{1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 3'd0, 6'h04};
    tbl[8]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 6'h04};
    tbl[9]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 3'd2, 6'h00};
    tbl[10] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 3'd0, 6'h00};
    tbl[11] = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 3'd0, 6'h01};
    tbl[12] = '{1'b1, 4'd4, 1'b0, 1'b1, 1'b1, 3'd0, 6'h09};
    tbl[13] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 3'd0, 6'h09};
    tbl[14] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 3'd0, 6'h08};
    tbl[15] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 3'd0, 6'h00};
    tbl[16] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 3'd3, 6'h00};
    tbl[17] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 3'd0, 6'h00};
    tbl[18] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 3'd3, 6'h00};
    tbl[19] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 3'd0, 6'h00};
    tbl[20] = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 3'd0, 6'h00};
    tbl[21] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 6'h00};
    tbl[22] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 6'h00};

    // Order after the simultaneous push/pop at full: old entries 2..8, then the new press.
    exp_p = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_l = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd1};

`ifdef TIMESTAMP_EN
    exp_time = 16'd2;
`else
    exp_time = 16'd0;
`endif

    key_reset        = 1'b0;
    key_state        = 1'b0;
    key_ascii        = 4'd0;
    ovf_clr          = 1'b0;
    evt_if.evt_ready = 1'b0;
    tick();
    tick();
    chk("reset.valid", 32'(evt_if.evt_valid), 32'd0);
    chk("reset.press", 32'(evt_if.evt_press), 32'd0);
    chk("reset.lane",  32'(evt_if.evt_lane),  32'd0);
    chk("reset.time",  32'(evt_if.evt_time),  32'd0);
    chk("reset.held",  32'(lane_held),        32'd0);
    chk("reset.ovf",   32'(ovf),              32'd0);
    @(negedge clk_in);
    key_reset = 1'b1;

    for (int i = 0; i < 23; i++) begin
      key_state        = tbl[i].st;
      key_ascii        = tbl[i].asc;
      evt_if.evt_ready = tbl[i].rdy;
      tick();
      chk($sformatf("row%0d.valid", i), 32'(evt_if.evt_valid), 32'(tbl[i].v));
      chk($sformatf("row%0d.press", i), 32'(evt_if.evt_press), 32'(tbl[i].p));
      chk($sformatf("row%0d.lane", i),  32'(evt_if.evt_lane),  32'(tbl[i].l));
      chk($sformatf("row%0d.held", i),  32'(lane_held),        32'(tbl[i].held));
    end
    evt_if.evt_ready = 1'b0;

    // Overflow: six presses then six drained releases into an 8-deep FIFO
    for (int i = 1; i <= 6; i++) begin
      key_state = 1'b1;
      key_ascii = 4'(i);
      tick();
    end
    chk("ovf.held_all", 32'(lane_held), 32'h3F);
    key_state = 1'b0;
    key_ascii = 4'd0;
    tick();
    tick();
    tick();
    chk("ovf.at_full", 32'(ovf), 32'd0);
    tick();
    chk("ovf.set", 32'(ovf), 32'd1);
    tick();
    tick();
    tick();
    chk("ovf.held_cleared", 32'(lane_held), 32'd0);
    chk("ovf.sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick();
    chk("ovf.cleared", 32'(ovf), 32'd0);
    key_state = 1'b1;
    key_ascii = 4'd1;
    tick();
    chk("ovf.set_beats_clr", 32'(ovf), 32'd1);
    chk("ovf.held_on_drop", 32'(lane_held), 32'h01);
    tick();
    chk("ovf.cleared_again", 32'(ovf), 32'd0);
    ovf_clr = 1'b0;

    // Push and pop together while full
    key_ascii        = 4'd2;
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    chk("full_pp.ovf", 32'(ovf), 32'd0);
    chk("full_pp.held", 32'(lane_held), 32'h03);
    for (int i = 0; i < 8; i++) pop_chk(exp_p[i], exp_l[i], $sformatf("full_pp.pop%0d", i));
    chk("full_pp.empty", 32'(evt_if.evt_valid), 32'd0);

    // Reset in the middle of a three-lane drain
    key_ascii = 4'd3;
    tick();
    chk("rst_drain.held3", 32'(lane_held), 32'h07);
    key_state = 1'b0;
    key_ascii = 4'd0;
    tick();
    tick();
    chk("rst_drain.draining", 32'(lane_held), 32'h06);
    key_reset = 1'b0;
    #1;
    chk("rst_drain.valid", 32'(evt_if.evt_valid), 32'd0);
    chk("rst_drain.press", 32'(evt_if.evt_press), 32'd0);
    chk("rst_drain.lane",  32'(evt_if.evt_lane),  32'd0);
    chk("rst_drain.held",  32'(lane_held),        32'd0);
    chk("rst_drain.ovf",   32'(ovf),              32'd0);
    tick();
    tick();
    @(negedge clk_in);
    key_reset = 1'b1;
    stray     = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      stray = stray | evt_if.evt_valid;
    end
    chk("rst_drain.no_stray", 32'(stray), 32'd0);
    key_state = 1'b1;
    key_ascii = 4'd1;
    tick();
    chk("stamp.valid", 32'(evt_if.evt_valid), 32'd1);
    chk("stamp.press", 32'(evt_if.evt_press), 32'd1);
    chk("stamp.lane",  32'(evt_if.evt_lane),  32'd0);
    chk("stamp.time",  32'(evt_if.evt_time),  32'(exp_time));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
